// File: rtl/up_down_mod_counter.sv
// Modulo-N up/down counter with clear, clamped parallel load, wrap/saturate bound
// handling, combinational terminal count and registered wrap/blocked event pulses.
module up_down_mod_counter #(
  parameter int size    = 4,
  parameter int modulus = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic [size-1:0] load_value,
  input  logic            enable,
  input  logic            mode,
  input  logic            saturate,
  output logic [size-1:0] count,
  output logic            tc,
  output logic            wrap,
  output logic            blocked
);

  generate
    if (size < 1 || modulus < 2 || modulus > (2 ** size)) begin : g_bad_cfg
      $error("up_down_mod_counter: modulus must lie in 2..2**size");
    end
  endgenerate

  // Bound compares are done one bit wider so modulus = 2**size is representable.
  localparam logic [size:0]   MOD_EXT = (size+1)'(modulus);
  localparam logic [size:0]   MAX_EXT = (size+1)'(modulus - 1);
  localparam logic [size-1:0] MAX_CNT = size'(modulus - 1);
  localparam logic [size-1:0] ONE     = size'(1);

  logic [size-1:0] r_count;
  logic            r_wrap;
  logic            r_blocked;
  logic            w_at_max;
  logic            w_at_zero;
  logic            w_load_ok;

  assign w_at_max  = ({1'b0, r_count} == MAX_EXT);
  assign w_at_zero = (r_count == '0);
  assign w_load_ok = ({1'b0, load_value} < MOD_EXT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_blocked <= 1'b0;
    end else if (clear) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_blocked <= 1'b0;
    end else if (load) begin
      r_count   <= w_load_ok ? load_value : MAX_CNT;
      r_wrap    <= 1'b0;
      r_blocked <= 1'b0;
    end else if (enable) begin
      r_wrap    <= 1'b0;
      r_blocked <= 1'b0;
      if (mode) begin
        if (!w_at_max) begin
          r_count <= r_count + ONE;
        end else if (!saturate) begin
          r_count <= '0;
          r_wrap  <= 1'b1;
        end else begin
          r_blocked <= 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          r_count <= r_count - ONE;
        end else if (!saturate) begin
          r_count <= MAX_CNT;
          r_wrap  <= 1'b1;
        end else begin
          r_blocked <= 1'b1;
        end
      end
    end else begin
      r_wrap    <= 1'b0;
      r_blocked <= 1'b0;
    end
  end

  assign count   = r_count;
  assign wrap    = r_wrap;
  assign blocked = r_blocked;
  assign tc      = mode ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Directed bench for up_down_mod_counter (size=4, modulus=10): vector table plus
// hand-written async-reset sequences.
module tb_up_down_mod_counter;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       mode;
  logic       saturate;
  logic [3:0] count;
  logic       tc;
  logic       wrap;
  logic       blocked;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic       mode;
    logic       saturate;
    logic [3:0] exp_count;
    logic       exp_tc;
    logic       exp_wrap;
    logic       exp_blocked;
  } vec_t;

  vec_t vecs[64];
  int   n_vec;

  up_down_mod_counter #(.size(4), .modulus(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .mode       (mode),
    .saturate   (saturate),
    .count      (count),
    .tc         (tc),
    .wrap       (wrap),
    .blocked    (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int e_cnt, input int e_tc,
                         input int e_wrap, input int e_blk);
    chk({name, ".count"},   int'(count),   e_cnt);
    chk({name, ".tc"},      int'(tc),      e_tc);
    chk({name, ".wrap"},    int'(wrap),    e_wrap);
    chk({name, ".blocked"}, int'(blocked), e_blk);
  endtask

  task automatic add(input logic c, input logic l, input logic [3:0] lv,
                     input logic en, input logic m, input logic s,
                     input logic [3:0] ec, input logic et, input logic ew,
                     input logic eb);
    vecs[n_vec] = '{c, l, lv, en, m, s, ec, et, ew, eb};
    n_vec++;
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                       input logic en, input logic m, input logic s);
    @(negedge clk);
    clear = c; load = l; load_value = lv; enable = en; mode = m; saturate = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_vec   = 0;

    // Up wrap from 0: 1..9 then 0 with wrap
    for (int i = 1; i <= 9; i++)
      add(0, 0, 0, 1, 1, 0, 4'(i), (i == 9), 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    // Down wrap and direction change
    add(0, 0, 0, 1, 0, 0, 9, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 8, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 9, 1, 0, 0);
    // Saturation up at 9
    add(0, 0, 0, 1, 1, 1, 9, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 9, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 9, 1, 0, 1);
    // Load 0 then saturated down
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    // Load / clear priority
    add(0, 1, 7,  0, 1, 0, 7, 0, 0, 0);
    add(0, 1, 12, 0, 1, 0, 9, 1, 0, 0);
    add(0, 1, 15, 0, 0, 0, 9, 0, 0, 0);
    add(0, 1, 3,  1, 1, 0, 3, 0, 0, 0);
    add(1, 1, 5,  1, 1, 0, 0, 0, 0, 0);
    // Enable hold at 6 while mode toggles
    add(0, 1, 6, 0, 1, 0, 6, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 6, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 6, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6, 0, 0, 0);
    // Hold at 0 (tc tracks mode) and at 9
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 9, 0, 1, 0, 9, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 9, 0, 0, 0);
    // Wrap pulse clears on hold
    add(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    clear = 0; load = 0; load_value = 0; enable = 0; mode = 0; saturate = 0;
    reset = 1'b1;
    #2;
    chk_all("reset_init", 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].clear, vecs[i].load, vecs[i].load_value,
            vecs[i].enable, vecs[i].mode, vecs[i].saturate);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].exp_count), int'(vecs[i].exp_tc),
              int'(vecs[i].exp_wrap), int'(vecs[i].exp_blocked));
    end

    // Async reset mid-count: count to 5 from a clear
    drive(1, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) drive(0, 0, 0, 1, 1, 0);
    chk_all("pre_reset", 5, 0, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("reset_held", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset_step", 1, 0, 0, 0);

    // Async reset clears a pending wrap pulse immediately
    drive(0, 1, 9, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    chk_all("wrap_before_reset", 0, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("reset_kills_wrap", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset clears a pending blocked pulse immediately
    drive(0, 1, 9, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 1);
    chk_all("blocked_before_reset", 9, 1, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("reset_kills_blocked", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
